sr_fifo_buf: RTL
================

// Module: sr_fifo_buf
// PURPOSE
//  Show-ahead synchronous FIFO behind the CPU PUSH/POP custom instructions.
//  PUSH writes rs1 data (writeEnable) at the clock edge. POP (readEnable) needs the head word
//  combinationally in the same cycle, so the register file captures it at the same edge.
//  Adds full/empty/count status, sticky overflow/underflow error flags and a high-water mark for debug.
// PARAMETERS
//  FIFO_DATA_WIDTH  32  width of each stored word
//  FIFO_DEPTH       8   number of entries; power of two, >= 2
//  AW               $clog2(FIFO_DEPTH)  pointer width (localparam, not overridable)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       asynchronous reset, active low
//  writeEnable  in   1       push request (PUSH instruction)
//  writeData    in   FIFO_DATA_WIDTH  word to push
//  readEnable   in   1       pop request (POP instruction)
//  readData     out  FIFO_DATA_WIDTH  head word, combinational (show-ahead)
//  full         out  1       count == FIFO_DEPTH
//  empty        out  1       count == 0
//  count        out  AW+1    current occupancy, 0..FIFO_DEPTH
//  overflow     out  1       sticky: push attempted while full and not popping
//  underflow    out  1       sticky: pop attempted while empty
//  errClr       in   1       synchronous clear of overflow/underflow
//  maxCount     out  AW+1    high-water mark of count since reset
// BEHAVIOUR
//  Reset (rst_n=0, async): wrPtr=rdPtr=0, count=0, overflow=underflow=0, maxCount=0.
//   Outputs: empty=1, full=0, readData=0. Storage array is not reset.
//  readData = empty ? 0 : mem[rdPtr]. No registered latency; pop consumes the word shown this cycle.
//  Push written word is visible on readData the cycle after the push edge; no write-to-read bypass.
//  Accept rules, evaluated per edge from pre-edge state:
//   doPop  = readEnable & ~empty
//   doPush = writeEnable & (~full | readEnable)
//   Full + push + pop: both succeed, count unchanged, head advances.
//   Empty + push + pop: pop rejected (underflow=1), push accepted, count 0->1.
//  Pointer update:
//   doPush: mem[wrPtr] <= writeData; wrPtr <= wrPtr+1, wraps modulo FIFO_DEPTH.
//   doPop:  rdPtr <= rdPtr+1, wraps modulo FIFO_DEPTH.
//  count <= count + doPush - doPop. count is an explicit register; never wraps, never exceeds FIFO_DEPTH.
//  Errors:
//   overflow  <= 1 on writeEnable & full & ~readEnable; dropped word is not stored, state unchanged.
//   underflow <= 1 on readEnable & empty; pointers are unchanged.
//   errClr clears both flags. Same-cycle new error + errClr: set wins.
//  maxCount <= max(maxCount, next count), updated every edge. Cleared only by reset.
//  Mid-operation reset returns to the empty state at once; contents are discarded.
//  No X on any output after reset, including readData while empty.
// TESTING
//  1 Reset, no stimulus -> empty=1, full=0, count=0, readData=0, overflow=underflow=0.
//  2 Push 0x11,0x22,0x33 on consecutive cycles:
//     -> count=3, readData=0x11.
//    Pop x3 -> readData 0x11,0x22,0x33 in pop cycles, then empty=1, maxCount=3.
//  3 Push 8 words (0xA0..0xA7), DEPTH=8 -> full=1.
//    Push 0xFF -> overflow=1, count=8, contents unchanged.
//    Pop all -> 0xA0..0xA7 in order.
//  4 Full FIFO, push 0xB0 with pop same cycle -> count stays 8, overflow=0.
//    Last word popped is 0xB0.
//  5 Empty, push 0x5 + pop same cycle -> underflow=1, count=1, next cycle readData=0x5.
//    errClr -> underflow=0.
//  6 Wrap: 20 interleaved push/pop of 0..19 at count 3..5 -> strict FIFO order, count consistent.
//    Assert rst_n=0 mid-stream -> empty=1 immediately.

Source files
------------

// File: rtl/sr_fifo_buf.sv
// Show-ahead synchronous FIFO for the PUSH/POP custom instructions.
// Provides occupancy status, sticky overflow/underflow flags and a high-water mark.
module sr_fifo_buf #(
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       writeEnable,
  input  logic [FIFO_DATA_WIDTH-1:0] writeData,
  input  logic                       readEnable,
  output logic [FIFO_DATA_WIDTH-1:0] readData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       errClr,
  output logic [$clog2(FIFO_DEPTH):0] maxCount
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   max_count_q, max_count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_CNT);

  // A pop frees the head slot at the same edge, so a full FIFO may still accept a push.
  assign do_pop  = readEnable & ~empty;
  assign do_push = writeEnable & (~full | readEnable);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Clear first so a fresh error in the same cycle wins over errClr.
    if (errClr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (writeEnable & full & ~readEnable) overflow_d  = 1'b1;
    if (readEnable & empty)               underflow_d = 1'b1;

    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; readData is gated by empty so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= writeData;
  end

  assign readData  = empty ? '0 : mem_q[rd_ptr_q];
  assign count     = count_q;
  assign maxCount  = max_count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
